// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if: ID/EX input bundle and EX/MEM output bundle of the execute stage.
// slave is the execute stage's view; master is the view of whoever drives ID/EX and consumes EX/MEM.
interface ex_stage_mc_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    // ID/EX side
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      wb_ctl;
    logic [2:0]      m_ctl;
    logic            regdst;
    logic            alusrc;
    logic [1:0]      aluop;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rd_a;
    logic [REGW-1:0] rd_b;

    // EX/MEM side
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      wb_ctl_out;
    logic            branch;
    logic            memread;
    logic            memwrite;
    logic [XLEN-1:0] branch_target;
    logic            zero;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rdata2_out;
    logic [REGW-1:0] rd_out;
    logic            busy;

    modport slave (
        input  in_valid, wb_ctl, m_ctl, regdst, alusrc, aluop, funct7, funct3,
               npc, rdata1, rdata2, imm, rd_a, rd_b, out_ready,
        output in_ready, out_valid, wb_ctl_out, branch, memread, memwrite,
               branch_target, zero, alu_result, rdata2_out, rd_out, busy
    );

    modport master (
        output in_valid, wb_ctl, m_ctl, regdst, alusrc, aluop, funct7, funct3,
               npc, rdata1, rdata2, imm, rd_a, rd_b, out_ready,
        input  in_ready, out_valid, wb_ctl_out, branch, memread, memwrite,
               branch_target, zero, alu_result, rdata2_out, rd_out, busy
    );
endinterface

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with integrated EX/MEM register.
// Single-cycle ALU ops land in EX/MEM on the accept edge. With EX_MULDIV_EN defined, RV32M-style
// multiply/divide ops run through an iterative XLEN-cycle shift-add / restoring-divide engine and
// stall ID/EX while busy. Without EX_MULDIV_EN every op is single-cycle and funct7=0000001 is an
// ordinary R-type op.
module ex_stage_mc #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic         clk,
    input  logic         reset,
    ex_stage_mc_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    // Everything that travels alongside the result into EX/MEM.
    typedef struct packed {
        logic [1:0]      wb;
        logic [2:0]      m;
        logic [XLEN-1:0] bt;
        logic [XLEN-1:0] st;
        logic [REGW-1:0] rd;
    } side_t;

    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    logic            is_muldiv;
    logic            load_single;
    logic            load_md;
    logic [XLEN-1:0] md_res;
    side_t           side_in;
    side_t           md_side;

    // Operand B select and the single-cycle ALU.
    always_comb begin
        alu_b   = bus.alusrc ? bus.imm : bus.rdata2;
        shamt   = alu_b[SHW-1:0];
        // NOTE: give every combinational output a value before any branch, otherwise an
        // uncovered path keeps the old value and synthesis infers a latch.
        alu_res = bus.rdata1 + alu_b;
        case (bus.aluop)
            2'b01: alu_res = bus.rdata1 - alu_b;
            2'b10: begin
                case (bus.funct3)
                    3'b000: if (bus.funct7[5] && !bus.alusrc) alu_res = bus.rdata1 - alu_b;
                    3'b001: alu_res = bus.rdata1 << shamt;
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(bus.rdata1) < $signed(alu_b)};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, bus.rdata1 < alu_b};
                    3'b100: alu_res = bus.rdata1 ^ alu_b;
                    3'b101: begin
                        // kept as separate statements so the arithmetic shift stays signed
                        if (bus.funct7[5]) alu_res = $signed(bus.rdata1) >>> shamt;
                        else               alu_res = bus.rdata1 >> shamt;
                    end
                    3'b110: alu_res = bus.rdata1 | alu_b;
                    default: alu_res = bus.rdata1 & alu_b;
                endcase
            end
            default: ;
        endcase
    end

    // Sideband fields captured with the instruction.
    always_comb begin
        side_in.wb = bus.wb_ctl;
        side_in.m  = bus.m_ctl;
        side_in.bt = bus.npc + bus.imm;
        side_in.st = bus.rdata2;
        side_in.rd = bus.regdst ? bus.rd_a : bus.rd_b;
    end

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [SHW-1:0]  cnt;
    logic            last_iter;
    logic            md_start;
    logic [XLEN-1:0] md_m;       // multiplicand or divisor magnitude
    logic [XLEN-1:0] md_hi;      // product high half / partial remainder
    logic [XLEN-1:0] md_lo;      // multiplier bits / quotient bits
    logic [2:0]      md_f3;
    logic            md_neg;     // negate product or quotient at the end
    logic            md_neg_r;   // negate remainder at the end
    logic            md_dz;      // divisor was zero
    logic            sgn_a;
    logic            sgn_b;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shl;
    logic [XLEN:0]   div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;

    assign is_muldiv = (bus.aluop == 2'b10) && (bus.funct7 == 7'b0000001) && !bus.alusrc;
    assign md_start  = bus.in_valid && bus.in_ready && is_muldiv;
    assign last_iter = (cnt == SHW'(XLEN - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of process order.
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:       if (md_start) state_nx = bus.funct3[2] ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (last_iter) state_nx = S_DONE;
            default:      if (!bus.out_valid || bus.out_ready) state_nx = S_IDLE;
        endcase
    end

    // FSM outputs: upstream stall, busy flag and the EX/MEM write strobe for muldiv results.
    always_comb begin
        bus.in_ready = (state == S_IDLE) && (!bus.out_valid || bus.out_ready);
        bus.busy     = (state != S_IDLE);
        load_md      = (state == S_DONE) && (!bus.out_valid || bus.out_ready);
    end

    // Operand signedness and magnitudes at accept; the engine itself is unsigned.
    always_comb begin
        if (bus.funct3[2]) begin
            sgn_a = !bus.funct3[0];
            sgn_b = !bus.funct3[0];
        end else begin
            sgn_a = (bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10);
            sgn_b = (bus.funct3[1:0] == 2'b01);
        end
        a_neg = sgn_a && bus.rdata1[XLEN-1];
        b_neg = sgn_b && bus.rdata2[XLEN-1];
        a_mag = a_neg ? -bus.rdata1 : bus.rdata1;
        b_mag = b_neg ? -bus.rdata2 : bus.rdata2;
    end

    // One shift-add step and one restoring-divide step.
    always_comb begin
        mul_sum  = {1'b0, md_hi} + {1'b0, (md_lo[0] ? md_m : {XLEN{1'b0}})};
        div_shl  = {md_hi, md_lo[XLEN-1]};
        div_diff = div_shl - {1'b0, md_m};
    end

    // Iteration counter; back at 0 after every complete op and after reset.
    always_ff @(posedge clk) begin
        if (reset)                                 cnt <= '0;
        else if (state == S_MUL || state == S_DIV) cnt <= cnt + 1'b1;
    end

    // Muldiv working registers.
    // NOTE: these are only read after md_start has loaded them, so they carry no reset and
    // stay plain enable flops.
    always_ff @(posedge clk) begin
        if (md_start) begin
            md_m     <= bus.funct3[2] ? b_mag : a_mag;
            md_lo    <= bus.funct3[2] ? a_mag : b_mag;
            md_hi    <= '0;
            md_f3    <= bus.funct3;
            md_neg   <= a_neg ^ b_neg;
            md_neg_r <= a_neg;
            md_dz    <= (bus.rdata2 == '0);
            md_side  <= side_in;
        end else if (state == S_MUL) begin
            {md_hi, md_lo} <= {mul_sum, md_lo[XLEN-1:1]};
        end else if (state == S_DIV) begin
            if (!div_diff[XLEN]) begin
                md_hi <= div_diff[XLEN-1:0];
                md_lo <= {md_lo[XLEN-2:0], 1'b1};
            end else begin
                md_hi <= div_shl[XLEN-1:0];
                md_lo <= {md_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign correction and result select for the finished op.
    always_comb begin
        prod_fix = md_neg ? -{md_hi, md_lo} : {md_hi, md_lo};
        quot     = md_dz ? {XLEN{1'b1}} : (md_neg ? -md_lo : md_lo);
        rem      = md_neg_r ? -md_hi : md_hi;
        if (md_f3[2])                 md_res = md_f3[1] ? rem : quot;
        else if (md_f3[1:0] == 2'b00) md_res = prod_fix[XLEN-1:0];
        else                          md_res = prod_fix[2*XLEN-1:XLEN];
    end
`else
    assign is_muldiv    = 1'b0;
    assign load_md      = 1'b0;
    assign md_res       = '0;
    assign md_side      = '0;
    assign bus.busy     = 1'b0;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
`endif

    assign load_single = bus.in_valid && bus.in_ready && !is_muldiv;

    // EX/MEM pipeline register: load a new result, hold under backpressure, or drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid     <= 1'b0;
            bus.wb_ctl_out    <= '0;
            bus.branch        <= 1'b0;
            bus.memread       <= 1'b0;
            bus.memwrite      <= 1'b0;
            bus.branch_target <= '0;
            bus.zero          <= 1'b0;
            bus.alu_result    <= '0;
            bus.rdata2_out    <= '0;
            bus.rd_out        <= '0;
        end else if (load_single) begin
            bus.out_valid     <= 1'b1;
            bus.wb_ctl_out    <= side_in.wb;
            {bus.branch, bus.memread, bus.memwrite} <= side_in.m;
            bus.branch_target <= side_in.bt;
            bus.zero          <= (alu_res == '0);
            bus.alu_result    <= alu_res;
            bus.rdata2_out    <= side_in.st;
            bus.rd_out        <= side_in.rd;
        end else if (load_md) begin
            bus.out_valid     <= 1'b1;
            bus.wb_ctl_out    <= md_side.wb;
            {bus.branch, bus.memread, bus.memwrite} <= md_side.m;
            bus.branch_target <= md_side.bt;
            bus.zero          <= (md_res == '0);
            bus.alu_result    <= md_res;
            bus.rdata2_out    <= md_side.st;
            bus.rd_out        <= md_side.rd;
        end else if (bus.out_ready) begin
            bus.out_valid     <= 1'b0;
        end
    end
endmodule
